register_file: RTL and testbench
================================

# register_file

Architectural integer register file for the RISC-V core: 32 × 32-bit registers, two read ports addressed by `rs1`/`rs2`, one write port driven by write-back. It is the consumer of the 5-bit `rs2` (and `rs1`) register index that decode drives. It returns registered operands to the execute stage, with write-back bypass, stall hold and flush. Sits between decode (addresses) and execute (operands), with write-back closing the loop.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register and operand width.
- `ADDR_WIDTH`, 5, register index width; 2^ADDR_WIDTH registers.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1`  in  ADDR_WIDTH  source register 1 index from decode.
- `rs2`  in  ADDR_WIDTH  source register 2 index from decode.
- `read_en`  in  1  capture new operands this cycle; 0 = stall/hold.
- `flush`  in  1  kill the operand slot (branch/jump redirect).
- `rd`  in  ADDR_WIDTH  write-back destination index.
- `write_data`  in  DATA_WIDTH  write-back data.
- `write_en`  in  1  write-back strobe.
- `rs1_data`  out  DATA_WIDTH  registered operand 1.
- `rs2_data`  out  DATA_WIDTH  registered operand 2.
- `operand_valid`  out  1  operand slot holds a live instruction.

## Operation
- Storage: 32 registers. x0 reads 0 at all times. Writes to x0 are discarded and no x0 storage is built.
- Write port: each rising edge with `write_en`=1 and `rd`≠0 stores `write_data` into reg[`rd`]. Writes proceed independently of `read_en` and `flush`.
- Read/capture, evaluated per edge in priority order:
  - `flush`=1: `rs1_data`, `rs2_data` ← 0 and `operand_valid` ← 0. Flush beats `read_en`.
  - else `read_en`=1: each operand ← bypass value; `operand_valid` ← 1.
  - else: hold all three outputs unchanged (stall).
- Bypass value for index r:
  - r=0 → 0.
  - else if `write_en`=1 and `rd`=r → `write_data` (write-first, same-edge forwarding).
  - else → reg[r].
- Both read ports may address the same register and may both hit the bypass simultaneously.
- Stall hold: outputs are frozen. A write landing on the held register during a stall does NOT update the held operand. Decode re-asserts `read_en` to re-read (hazard unit's responsibility).
- All widths exact: no sign/zero extension inside the block.

## Timing
- Reset (`rst_n`=0, asynchronous assert, synchronous-release expectation): all 31 registers = 0, `rs1_data`=0, `rs2_data`=0, `operand_valid`=0, held for the duration of reset.
- Read latency: 1 cycle. Address presented with `read_en` before edge N gives data on outputs after edge N.
- Write latency: reg[`rd`] visible to a non-bypassed read from the edge after the write edge. The bypass covers the same edge, so there is zero-bubble RAW across write-back → read.
- Reset mid-operation: pending write in the same cycle is lost; outputs return to reset values immediately (no clock needed).
- `flush` and `write_en` in the same cycle: write commits, operands cleared.
- `flush` with `read_en`=0: still clears (flush overrides stall).

## Test plan
- Reset/x0: assert `rst_n`=0 mid-run → outputs 0 asynchronously. Release. `write_en`=1, `rd`=0, `write_data`=0xDEADBEEF, then read `rs1`=`rs2`=0 → both 0x00000000, `operand_valid`=1.
- Basic write/read:
  - write x5=0x12345678, then x31=0xFFFFFFFF.
  - next cycle `rs1`=5, `rs2`=31, `read_en`=1 → after 1 edge `rs1_data`=0x12345678, `rs2_data`=0xFFFFFFFF.
- Same-edge bypass: x7 holds 0x1. In one cycle `write_en`=1, `rd`=7, `write_data`=0xA5A5A5A5, `rs1`=`rs2`=7, `read_en`=1 → both outputs 0xA5A5A5A5.
- Stall hold: capture `rs2`=3 (value 0x10). Then `read_en`=0 for 3 cycles while writing x3=0x20 → `rs2_data` stays 0x10, `operand_valid` stays 1. Then `read_en`=1 → 0x20.
- Flush priority: `flush`=1, `read_en`=1, `write_en`=1, `rd`=9, `write_data`=0x55 → outputs 0, `operand_valid`=0. Next read of x9 → 0x55.
- Sweep: write reg[i]=i×0x01010101 for i=1..31, read back all pairs (i, 31−i) → exact values; pairs involving i=0 read 0.

Source files
------------

// File: rtl/register_file_if.sv
// ============================================================================
// Module      : register_file_if
// Description : Decode/write-back to register-file bus (read addresses, write port, operands)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  read_en;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic                  operand_valid;

    modport master (
        output rs1, rs2, read_en, flush, rd, write_data, write_en,
        input  rs1_data, rs2_data, operand_valid
    );

    modport slave (
        input  rs1, rs2, read_en, flush, rd, write_data, write_en,
        output rs1_data, rs2_data, operand_valid
    );
endinterface

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module      : register_file
// Description : 32x32 RISC-V integer register file, registered operands with
//               write-back bypass, stall hold and flush
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire                  clk,
    input  wire                  rst_n,
    register_file_if.slave       bus
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // Entry 0 is a constant zero; only entries 1..NUM_REGS-1 have storage.
    logic [DATA_WIDTH-1:0] w_rf [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_rs1_val;
    logic [DATA_WIDTH-1:0] w_rs2_val;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic                  r_operand_valid;

    assign w_rf[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_WIDTH-1:0] c_IDX = ADDR_WIDTH'(gi);
            logic [DATA_WIDTH-1:0] r_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q <= '0;
                end else if (bus.write_en && (bus.rd == c_IDX)) begin
                    r_q <= bus.write_data;
                end
            end

            assign w_rf[gi] = r_q;
        end
    endgenerate

    // Write-first forwarding: a same-edge write to the addressed register wins.
    always_comb begin
        w_rs1_val = w_rf[bus.rs1];
        if (bus.write_en && (bus.rs1 != '0) && (bus.rd == bus.rs1)) begin
            w_rs1_val = bus.write_data;
        end
    end

    always_comb begin
        w_rs2_val = w_rf[bus.rs2];
        if (bus.write_en && (bus.rs2 != '0) && (bus.rd == bus.rs2)) begin
            w_rs2_val = bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_data      <= '0;
            r_rs2_data      <= '0;
            r_operand_valid <= 1'b0;
        end else if (bus.flush) begin
            r_rs1_data      <= '0;
            r_rs2_data      <= '0;
            r_operand_valid <= 1'b0;
        end else if (bus.read_en) begin
            r_rs1_data      <= w_rs1_val;
            r_rs2_data      <= w_rs2_val;
            r_operand_valid <= 1'b1;
        end
    end

    assign bus.rs1_data      = r_rs1_data;
    assign bus.rs2_data      = r_rs2_data;
    assign bus.operand_valid = r_operand_valid;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file against an array model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [31:0] mem [32];
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        expv;

    register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] src_value(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.write_en && bus.rd == r) return bus.write_data;
        return mem[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        exp1 = 32'd0;
        exp2 = 32'd0;
        expv = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.rs1 = '0; bus.rs2 = '0; bus.read_en = 1'b0; bus.flush = 1'b0;
        bus.rd = '0; bus.write_data = '0; bus.write_en = 1'b0;
    endtask

    // Advance one clock edge, updating the model from the inputs currently driven.
    task automatic step();
        if (bus.flush) begin
            exp1 = 32'd0; exp2 = 32'd0; expv = 1'b0;
        end else if (bus.read_en) begin
            exp1 = src_value(bus.rs1);
            exp2 = src_value(bus.rs2);
            expv = 1'b1;
        end
        if (bus.write_en && bus.rd != 5'd0) mem[bus.rd] = bus.write_data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [31:0] d);
        idle_inputs();
        bus.write_en = 1'b1; bus.rd = r; bus.write_data = d;
        step();
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        idle_inputs();
        bus.read_en = 1'b1; bus.rs1 = a; bus.rs2 = b;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0 || bus.operand_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got %h %h v=%b want 0 0 v=0", bus.rs1_data, bus.rs2_data, bus.operand_valid);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        do_read(5'd1, 5'd31);
        total++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0 || bus.operand_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_regs_zero: got %h %h v=%b want 0 0 v=1", bus.rs1_data, bus.rs2_data, bus.operand_valid);
        end
    endtask

    task automatic test_x0();
        do_write(5'd0, 32'hDEADBEEF);
        do_read(5'd0, 5'd0);
        total++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0 || bus.operand_valid !== 1'b1) begin
            bad++;
            $display("FAIL x0_read: got %h %h v=%b want 0 0 v=1", bus.rs1_data, bus.rs2_data, bus.operand_valid);
        end
        idle_inputs();
        bus.write_en = 1'b1; bus.rd = 5'd0; bus.write_data = 32'hCAFEF00D;
        bus.read_en = 1'b1; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        step();
        total++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0) begin
            bad++;
            $display("FAIL x0_no_bypass: got %h %h want 0 0", bus.rs1_data, bus.rs2_data);
        end
    endtask

    task automatic test_basic();
        do_write(5'd5, 32'h12345678);
        do_write(5'd31, 32'hFFFFFFFF);
        do_read(5'd5, 5'd31);
        total++;
        if (bus.rs1_data !== 32'h12345678 || bus.rs2_data !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL basic_rw: got %h %h want 12345678 ffffffff", bus.rs1_data, bus.rs2_data);
        end
    endtask

    task automatic test_bypass();
        do_write(5'd7, 32'h1);
        idle_inputs();
        bus.write_en = 1'b1; bus.rd = 5'd7; bus.write_data = 32'hA5A5A5A5;
        bus.read_en = 1'b1; bus.rs1 = 5'd7; bus.rs2 = 5'd7;
        step();
        total++;
        if (bus.rs1_data !== 32'hA5A5A5A5 || bus.rs2_data !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_same_edge: got %h %h want a5a5a5a5 a5a5a5a5", bus.rs1_data, bus.rs2_data);
        end
        do_read(5'd7, 5'd5);
        total++;
        if (bus.rs1_data !== 32'hA5A5A5A5 || bus.rs2_data !== 32'h12345678) begin
            bad++;
            $display("FAIL bypass_committed: got %h %h want a5a5a5a5 12345678", bus.rs1_data, bus.rs2_data);
        end
    endtask

    task automatic test_stall();
        do_write(5'd3, 32'h10);
        do_read(5'd0, 5'd3);
        for (int k = 0; k < 3; k++) begin
            do_write(5'd3, 32'h20);
            total++;
            if (bus.rs2_data !== 32'h10 || bus.operand_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got %h v=%b want 00000010 v=1", k, bus.rs2_data, bus.operand_valid);
            end
        end
        do_read(5'd0, 5'd3);
        total++;
        if (bus.rs2_data !== 32'h20) begin
            bad++;
            $display("FAIL stall_reread: got %h want 00000020", bus.rs2_data);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.flush = 1'b1; bus.read_en = 1'b1; bus.rs1 = 5'd3; bus.rs2 = 5'd9;
        bus.write_en = 1'b1; bus.rd = 5'd9; bus.write_data = 32'h55;
        step();
        total++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0 || bus.operand_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_priority: got %h %h v=%b want 0 0 v=0", bus.rs1_data, bus.rs2_data, bus.operand_valid);
        end
        do_read(5'd9, 5'd9);
        total++;
        if (bus.rs1_data !== 32'h55 || bus.operand_valid !== 1'b1) begin
            bad++;
            $display("FAIL flush_write_commit: got %h v=%b want 00000055 v=1", bus.rs1_data, bus.operand_valid);
        end
        idle_inputs();
        bus.flush = 1'b1;
        step();
        total++;
        if (bus.rs1_data !== 32'd0 || bus.operand_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_over_stall: got %h v=%b want 0 v=0", bus.rs1_data, bus.operand_valid);
        end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1;
            logic [31:0] e2;
            e1 = 32'(i) * 32'h01010101;
            e2 = 32'(31 - i) * 32'h01010101;
            do_read(5'(i), 5'(31 - i));
            total++;
            if (bus.rs1_data !== e1 || bus.rs2_data !== e2) begin
                bad++;
                $display("FAIL sweep[%0d]: got %h %h want %h %h", i, bus.rs1_data, bus.rs2_data, e1, e2);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.rs1        = 5'($urandom_range(0, 31));
            bus.rs2        = ($urandom_range(0, 3) == 0) ? bus.rs1 : 5'($urandom_range(0, 31));
            bus.read_en    = 1'($urandom_range(0, 3) != 0);
            bus.flush      = 1'($urandom_range(0, 9) == 0);
            bus.write_en   = 1'($urandom_range(0, 1));
            bus.rd         = ($urandom_range(0, 2) == 0) ? bus.rs1 : 5'($urandom_range(0, 31));
            bus.write_data = $urandom();
            step();
            total++;
            if (bus.rs1_data !== exp1 || bus.rs2_data !== exp2 || bus.operand_valid !== expv) begin
                bad++;
                $display("FAIL random[%0d]: got %h %h v=%b want %h %h v=%b",
                         n, bus.rs1_data, bus.rs2_data, bus.operand_valid, exp1, exp2, expv);
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_write(5'd12, 32'h0BADF00D);
        do_read(5'd12, 5'd12);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0 || bus.operand_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun: got %h %h v=%b want 0 0 v=0", bus.rs1_data, bus.rs2_data, bus.operand_valid);
        end
        idle_inputs();
        bus.write_en = 1'b1; bus.rd = 5'd13; bus.write_data = 32'h77777777;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_read(5'd12, 5'd13);
        total++;
        if (bus.rs1_data !== 32'd0 || bus.rs2_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_clears_regs: got %h %h want 0 0", bus.rs1_data, bus.rs2_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_x0();
        test_basic();
        test_bypass();
        test_stall();
        test_flush();
        test_sweep();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
